// File: rtl/bcd_calc_pkg.sv
// Shared definitions for the serial BCD calculator.
// Holds the FSM state encoding, the BCD digit width and the digit helper
// functions used by the top level.
package bcd_calc_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // 9's complement of one BCD digit (input assumed 0..9).
  function automatic logic [BCD_W-1:0] nines_comp(input logic [BCD_W-1:0] d);
    return BCD_W'(4'd9 - d);
  endfunction

  // True when a nibble is not a legal BCD digit.
  function automatic logic digit_bad(input logic [BCD_W-1:0] d);
    return (d > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_seq_calc_digit_adder.sv
// Combinational one-digit BCD adder.
// Ports:
//   i_a, i_b : BCD digits (0..9)
//   i_cin    : carry in
//   o_sum    : decimal-corrected sum digit (0..9)
//   o_cout   : decimal carry out
module bcd_digit_adder
  import bcd_calc_pkg::*;
(
  input  logic [BCD_W-1:0] i_a,
  input  logic [BCD_W-1:0] i_b,
  input  logic             i_cin,
  output logic [BCD_W-1:0] o_sum,
  output logic             o_cout
);

  logic [BCD_W:0] w_raw;

  // Binary sum is at most 9+9+1 = 19, so one subtraction of 10 suffices.
  assign w_raw  = {1'b0, i_a} + {1'b0, i_b} + {{BCD_W{1'b0}}, i_cin};
  assign o_cout = (w_raw > (BCD_W+1)'(9));
  assign o_sum  = o_cout ? BCD_W'(w_raw - (BCD_W+1)'(10)) : w_raw[BCD_W-1:0];

endmodule

// File: rtl/bcd_seq_calc.sv
// Serial packed-BCD add/subtract unit, one digit per clock, LSD first.
// Ports:
//   CLOCK_50  : clock, rising edge
//   rst       : synchronous active-high reset
//   start     : operation request, sampled only in IDLE
//   mode      : 0 = a+b, 1 = a-b (sampled with start)
//   a, b      : packed BCD operands, LSD in [3:0]
//   busy      : high in CALC and FIX
//   done      : one-cycle completion pulse
//   result    : packed BCD result (|a-b| for a negative subtraction)
//   ovf       : addition carried out of the MSD
//   neg       : subtraction had a<b
//   err       : an operand digit was > 9 at acceptance
//   dbg_state : current FSM state
//
// Handshake: a request is accepted on any rising edge where the FSM is IDLE
// and start=1; there is no ready signal, so start outside IDLE is simply
// dropped. busy covers the working cycles, done pulses for exactly one cycle
// when the result/flags become valid, and they then hold until the next
// accepted request.
module bcd_seq_calc
  import bcd_calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] result,
  output logic                    ovf,
  output logic                    neg,
  output logic                    err,
  output logic [1:0]              dbg_state
);

  localparam int W     = BCD_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_mode;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [W-1:0]       r_result;
  logic               r_ovf;
  logic               r_neg;
  logic               r_err;

  logic               w_bad;
  logic               w_last;
  logic [BCD_W-1:0]   w_op_a;
  logic [BCD_W-1:0]   w_op_b;
  logic [BCD_W-1:0]   w_sum;
  logic               w_cout;

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      w_bad = w_bad | digit_bad(a[i*BCD_W +: BCD_W]) | digit_bad(b[i*BCD_W +: BCD_W]);
    end
  end

  assign w_last = (r_idx == IDX_W'(DIGITS - 1));

  // The single adder is shared: CALC adds a to b (or 9's complement of b),
  // FIX adds the 9's complement of the stored result to zero with the
  // carry chain seeded to 1, giving the 10's complement.
  always_comb begin
    w_op_a = r_a[r_idx*BCD_W +: BCD_W];
    w_op_b = r_mode ? nines_comp(r_b[r_idx*BCD_W +: BCD_W]) : r_b[r_idx*BCD_W +: BCD_W];
    if (r_state == S_FIX) begin
      w_op_a = nines_comp(r_result[r_idx*BCD_W +: BCD_W]);
      w_op_b = '0;
    end
  end

  bcd_digit_adder u_adder (
    .i_a   (w_op_a),
    .i_b   (w_op_b),
    .i_cin (r_carry),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_bad ? S_DONE : S_CALC;
      S_CALC: if (w_last) w_next = (r_mode && !w_cout) ? S_FIX : S_DONE;
      S_FIX:  if (w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= 1'b0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_mode   <= mode;
            r_idx    <= '0;
            r_carry  <= mode;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_neg    <= 1'b0;
            r_err    <= w_bad;
          end
        end
        S_CALC: begin
          r_result[r_idx*BCD_W +: BCD_W] <= w_sum;
          r_carry <= w_cout;
          if (w_last) begin
            r_idx <= '0;
            if (!r_mode) begin
              r_ovf <= w_cout;
            end else if (!w_cout) begin
              // No final borrow-free carry: a<b, result is 10's complement.
              r_neg   <= 1'b1;
              r_carry <= 1'b1;
            end
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_FIX: begin
          r_result[r_idx*BCD_W +: BCD_W] <= w_sum;
          r_carry <= w_cout;
          r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state == S_CALC) || (r_state == S_FIX);
  assign done      = (r_state == S_DONE);
  assign result    = r_result;
  assign ovf       = r_ovf;
  assign neg       = r_neg;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_seq_calc.sv
// Self-checking bench for bcd_seq_calc (DIGITS=4). Expected values come from
// integer arithmetic on the decimal values of the operands.
module tb_bcd_seq_calc;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         CLOCK_50 = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         ovf;
  logic         neg;
  logic         err;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  bcd_seq_calc #(.DIGITS(DIGITS)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .ovf      (ovf),
    .neg      (neg),
    .err      (err),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model helpers ----------------
  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit r = 0;
    for (int i = 0; i < DIGITS; i++) if (v[i*4 +: 4] > 4'd9) r = 1;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    return int2bcd(int'($urandom_range(0, 9999)));
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble inputs while in flight, optionally poke
  // start during busy, then verify latency, outputs, pulse width and hold.
  task automatic run_op(input logic m, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input bit poke_start);
    int           ia, ib, lat, n, busy_cnt;
    logic [W-1:0] er;
    logic         eo, en, ee;
    ee = has_bad(va) || has_bad(vb);
    ia = 0; ib = 0;
    if (!ee) begin ia = bcd2int(va); ib = bcd2int(vb); end
    if (ee) begin
      er = '0; eo = 0; en = 0; lat = 0;
    end else if (!m) begin
      er = int2bcd((ia + ib) % 10000); eo = (ia + ib) >= 10000; en = 0; lat = DIGITS;
    end else if (ia >= ib) begin
      er = int2bcd(ia - ib); eo = 0; en = 0; lat = DIGITS;
    end else begin
      er = int2bcd(ib - ia); eo = 0; en = 1; lat = 2 * DIGITS;
    end

    start = 1'b1; mode = m; a = va; b = vb;
    tick();
    start = 1'b0;
    check("busy_after_accept", {31'b0, busy}, {31'b0, !ee});
    n = 0; busy_cnt = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_cnt++;
      a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
      start = (poke_start && n == 1);
      tick();
      n++;
    end
    start = 1'b0;
    check("latency", n, lat);
    check("busy_cycles", busy_cnt, lat);
    check("result", {16'b0, result}, {16'b0, er});
    check("ovf", {31'b0, ovf}, {31'b0, eo});
    check("neg", {31'b0, neg}, {31'b0, en});
    check("err", {31'b0, err}, {31'b0, ee});

    // start during DONE is ignored; outputs hold afterwards
    start = 1'b1; a = rand_bcd(); b = rand_bcd(); mode = 1'($urandom);
    tick();
    start = 1'b0;
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("no_start_in_done", {31'b0, busy}, 32'd0);
    check("result_hold", {16'b0, result}, {16'b0, er});
    check("flags_hold", {29'b0, ovf, neg, err}, {29'b0, eo, en, ee});
    tick();
    check("idle_no_queue", {30'b0, busy, done}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    tick(); tick();
    check("reset_outputs", {result, 12'b0, busy, done, ovf, neg, err},
          32'd0);
    rst = 1'b0;
    tick();
    check("post_reset_outputs", {result, 12'b0, busy, done, ovf, neg, err},
          32'd0);

    run_op(1'b0, 16'h1234, 16'h5678, 1'b0);
    run_op(1'b0, 16'h9999, 16'h0001, 1'b0);
    run_op(1'b1, 16'h5000, 16'h1234, 1'b0);
    run_op(1'b1, 16'h0012, 16'h0345, 1'b0);
    run_op(1'b0, 16'h12A4, 16'h0001, 1'b0);
    run_op(1'b0, 16'h0456, 16'h0123, 1'b1);
    run_op(1'b1, 16'h4321, 16'h4321, 1'b0);
    run_op(1'b1, 16'h0000, 16'h0001, 1'b1);

    // reset in the middle of CALC
    start = 1'b1; mode = 1'b0; a = 16'h1234; b = 16'h5678;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_calc", {result, 12'b0, busy, done, ovf, neg, err}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      tick();
    end
    check("rst_no_done", pulses, 0);

    // reset wins over a simultaneous start
    rst = 1'b1; start = 1'b1; mode = 1'b0; a = 16'h0005; b = 16'h0005;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_priority", {30'b0, busy, done}, 32'd0);
    tick();
    check("rst_priority_idle", {30'b0, busy, done}, 32'd0);

    // randomized operations
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      ra = rand_bcd();
      rb = rand_bcd();
      if (i % 10 == 9) ra[4*($urandom_range(0, DIGITS-1)) +: 4] = 4'($urandom_range(10, 15));
      run_op(1'($urandom), ra, rb, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
